// File: rtl/uart_top.sv
// uart_top: byte-wide full-duplex UART (8N1) with a live status byte and a
// one-cycle-delayed copy of that status held in an always-enabled register.
// All state is reset asynchronously by the active-high resetn input.
module uart_top #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       ex_clk,
    input  logic       resetn,
    input  logic       rx_pin,
    output logic       tx_pin,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    input  logic [7:0] ctrl,
    output logic [7:0] uart_state,
    output logic [7:0] status_q
);

    // Bit-period counters run 1..CLKS_PER_BIT; an interval expires when the
    // counter equals CLKS_PER_BIT.
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_fsm_t;

    // Reserved control bits are deliberately ignored.
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl[7:2];

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_fsm_t        tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             tx_pin_reg, tx_pin_next;
    logic             tx_busy_reg, tx_busy_next;
    logic             tx_done_reg, tx_done_next;
    logic             start_prev_reg;
    logic             tx_go;

    // A frame may only start on a 0->1 transition of ctrl[1]; holding it high
    // never starts a second frame.
    assign tx_go = ctrl[1] & ~start_prev_reg;

    // TX next-state: tx_pin is registered, so each state drives its bit from
    // the edge on which it is entered.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_pin_next   = tx_pin_reg;
        tx_busy_next  = tx_busy_reg;
        tx_done_next  = tx_done_reg;
        case (tx_state_reg)
            ST_IDLE: begin
                tx_pin_next = 1'b1;
                if (tx_go) begin
                    tx_state_next = ST_START;
                    tx_shift_next = tx_data;
                    tx_cnt_next   = CNT_W'(1);
                    tx_pin_next   = 1'b0;
                    tx_busy_next  = 1'b1;
                    tx_done_next  = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_state_next = ST_DATA;
                    tx_cnt_next   = CNT_W'(1);
                    tx_bit_next   = 3'd0;
                    tx_pin_next   = tx_shift_reg[0];
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next = CNT_W'(1);
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = ST_STOP;
                        tx_pin_next   = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_pin_next   = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_state_next = ST_IDLE;
                    tx_busy_next  = 1'b0;
                    tx_done_next  = 1'b1;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: begin
                tx_state_next = ST_IDLE;
                tx_pin_next   = 1'b1;
            end
        endcase
    end

    // TX state register plus the ctrl[1] edge-detect history.
    always_ff @(posedge ex_clk or posedge resetn) begin
        if (resetn) begin
            tx_state_reg   <= ST_IDLE;
            tx_cnt_reg     <= '0;
            tx_bit_reg     <= '0;
            tx_shift_reg   <= '0;
            tx_pin_reg     <= 1'b1;
            tx_busy_reg    <= 1'b0;
            tx_done_reg    <= 1'b0;
            start_prev_reg <= 1'b0;
        end else begin
            tx_state_reg   <= tx_state_next;
            tx_cnt_reg     <= tx_cnt_next;
            tx_bit_reg     <= tx_bit_next;
            tx_shift_reg   <= tx_shift_next;
            tx_pin_reg     <= tx_pin_next;
            tx_busy_reg    <= tx_busy_next;
            tx_done_reg    <= tx_done_next;
            start_prev_reg <= ctrl[1];
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_in;

    generate
        if (CLKS_PER_BIT == 1) begin : g_rx_direct
            // At one clock per bit there is no slack for synchroniser latency.
            assign rx_in = rx_pin;
        end else begin : g_rx_sync
            logic [1:0] sync_reg;
            // Two-flop synchroniser; resets to the idle-high line level.
            always_ff @(posedge ex_clk or posedge resetn) begin
                if (resetn) begin
                    sync_reg <= 2'b11;
                end else begin
                    sync_reg <= {sync_reg[0], rx_pin};
                end
            end
            assign rx_in = sync_reg[1];
        end
    endgenerate

    uart_fsm_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;
    logic [7:0]       rx_data_reg, rx_data_next;
    logic             rx_busy_reg, rx_busy_next;
    logic             rx_done_reg, rx_done_next;
    logic             frame_err_reg, frame_err_next;

    // RX next-state: detect start, re-check it at mid-bit, then sample every
    // bit period. rx_done clears on ctrl[0] unless it is being set this edge.
    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_bit_next    = rx_bit_reg;
        rx_shift_next  = rx_shift_reg;
        rx_data_next   = rx_data_reg;
        rx_busy_next   = rx_busy_reg;
        rx_done_next   = rx_done_reg & ~ctrl[0];
        frame_err_next = frame_err_reg;
        case (rx_state_reg)
            ST_IDLE: begin
                if (!rx_in) begin
                    rx_busy_next = 1'b1;
                    rx_cnt_next  = CNT_W'(1);
                    rx_bit_next  = 3'd0;
                    if (HALF == 0) begin
                        // Mid-bit is the detection edge itself.
                        rx_state_next = ST_DATA;
                        rx_done_next  = 1'b0;
                    end else begin
                        rx_state_next = ST_START;
                    end
                end
            end
            ST_START: begin
                if (rx_cnt_reg == HALF_CNT) begin
                    rx_cnt_next = CNT_W'(1);
                    if (!rx_in) begin
                        rx_state_next = ST_DATA;
                        rx_done_next  = 1'b0;
                    end else begin
                        // Glitch: back to idle with no status change.
                        rx_state_next = ST_IDLE;
                        rx_busy_next  = 1'b0;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = CNT_W'(1);
                    rx_shift_next = {rx_in, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = ST_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_state_next = ST_IDLE;
                    rx_busy_next  = 1'b0;
                    if (rx_in) begin
                        rx_data_next   = rx_shift_reg;
                        rx_done_next   = 1'b1;
                        frame_err_next = 1'b0;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: begin
                rx_state_next = ST_IDLE;
            end
        endcase
    end

    // RX state register.
    always_ff @(posedge ex_clk or posedge resetn) begin
        if (resetn) begin
            rx_state_reg  <= ST_IDLE;
            rx_cnt_reg    <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            rx_busy_reg   <= 1'b0;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            rx_data_reg   <= rx_data_next;
            rx_busy_reg   <= rx_busy_next;
            rx_done_reg   <= rx_done_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    logic [7:0] status_q_reg;
    logic       status_en;

    assign status_en  = 1'b1;
    assign uart_state = {3'b000, frame_err_reg, tx_done_reg, rx_done_reg,
                         rx_busy_reg, tx_busy_reg};

    // Enable register capturing the live status every cycle.
    always_ff @(posedge ex_clk or posedge resetn) begin
        if (resetn) begin
            status_q_reg <= '0;
        end else if (status_en) begin
            status_q_reg <= uart_state;
        end
    end

    assign tx_pin   = tx_pin_reg;
    assign rx_data  = rx_data_reg;
    assign status_q = status_q_reg;

endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: directed checks of uart_top at one clock per bit, plus a
// full-duplex run on a second instance at four clocks per bit.
module tb_uart_top;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_pin, tx_pin;
    logic [7:0] tx_data, rx_data, ctrl, uart_state, status_q;
    logic       rx_pin4, tx_pin4;
    logic [7:0] tx_data4, rx_data4, ctrl4, uart_state4, status_q4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_top #(.CLKS_PER_BIT(1)) dut (
        .ex_clk(clk), .resetn(resetn), .rx_pin(rx_pin), .tx_pin(tx_pin),
        .tx_data(tx_data), .rx_data(rx_data), .ctrl(ctrl),
        .uart_state(uart_state), .status_q(status_q)
    );

    uart_top #(.CLKS_PER_BIT(4)) dut4 (
        .ex_clk(clk), .resetn(resetn), .rx_pin(rx_pin4), .tx_pin(tx_pin4),
        .tx_data(tx_data4), .rx_data(rx_data4), .ctrl(ctrl4),
        .uart_state(uart_state4), .status_q(status_q4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one 10-bit frame (bit 0 first) one bit per cycle; returns at the
    // negedge after the stop bit was sampled, with the line back at idle.
    task automatic rx_frame(input logic [9:0] f);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_pin = f[i];
        end
        @(negedge clk);
        rx_pin = 1'b1;
    endtask

    // Send one byte and check every line bit, then tx_done at the end.
    task automatic tx_run(input logic [7:0] d);
        logic [9:0] exp_f;
        exp_f   = {1'b1, d, 1'b0};
        tx_data = d;
        ctrl[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ctrl[1] = 1'b0;
                chk("tx_done_clr", uart_state[3], 1'b0);
                chk("tx_busy", uart_state[0], 1'b1);
            end
            chk($sformatf("tx_bit%0d", i), tx_pin, exp_f[i]);
        end
        @(negedge clk);
        chk("tx_idle", tx_pin, 1'b1);
        chk("tx_done", uart_state[3], 1'b1);
        chk("tx_busy_end", uart_state[0], 1'b0);
        $display("tx frame %02h sent", d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f;
        logic [9:0] rxf4, txf4;
        logic [7:0] prev4;

        resetn = 1'b1; rx_pin = 1'b1; ctrl = '0; tx_data = '0;
        rx_pin4 = 1'b1; ctrl4 = '0; tx_data4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_tx_pin", tx_pin, 1'b1);
        chk("rst_state", uart_state, 8'h00);
        chk("rst_status_q", status_q, 8'h00);
        chk("rst_rx_data", rx_data, 8'h00);
        resetn = 1'b0;
        @(negedge clk);

        // Valid RX frames.
        rx_frame(10'b1001101110);
        chk("rx0_data", rx_data, 8'b00110111);
        chk("rx0_done", uart_state[2], 1'b1);
        chk("rx0_busy", uart_state[1], 1'b0);
        chk("rx0_stq_lag", status_q, 8'h02);
        $display("rx frame got %02h", rx_data);
        @(negedge clk);
        chk("rx0_stq_next", status_q, 8'h04);
        rx_frame(10'b1000001000);
        chk("rx1_data", rx_data, 8'b00000100);
        chk("rx1_done", uart_state[2], 1'b1);
        $display("rx frame got %02h", rx_data);
        rx_frame(10'b1111100110);
        chk("rx2_data", rx_data, 8'b11110011);
        chk("rx2_done", uart_state[2], 1'b1);
        $display("rx frame got %02h", rx_data);

        // Framing error: stop bit low.
        f = {1'b0, 8'h55, 1'b0};
        rx_frame(f);
        chk("ferr_flag", uart_state[4], 1'b1);
        chk("ferr_done", uart_state[2], 1'b0);
        chk("ferr_data", rx_data, 8'hF3);
        ctrl[0] = 1'b1;
        @(negedge clk);
        ctrl[0] = 1'b0;
        chk("ferr_clr_done", uart_state[2], 1'b0);
        $display("rx framing error frame done");

        // Valid frame with ctrl[0] held: set beats clear, then clear applies.
        ctrl[0] = 1'b1;
        rx_frame(10'b1001101110);
        chk("setwin_done", uart_state[2], 1'b1);
        chk("setwin_ferr", uart_state[4], 1'b0);
        chk("setwin_data", rx_data, 8'h37);
        @(negedge clk);
        chk("clr_done", uart_state[2], 1'b0);
        ctrl[0] = 1'b0;
        $display("rx frame with ctrl0 held got %02h", rx_data);

        // Asynchronous reset in the middle of a TX frame.
        tx_data = 8'h00;
        ctrl[1] = 1'b1;
        @(negedge clk);
        ctrl[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_pin", tx_pin, 1'b0);
        chk("pre_rst_busy", uart_state[0], 1'b1);
        #2 resetn = 1'b1;
        #1;
        chk("arst_tx_pin", tx_pin, 1'b1);
        chk("arst_state", uart_state, 8'h00);
        chk("arst_rx_data", rx_data, 8'h00);
        chk("arst_status_q", status_q, 8'h00);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        $display("async reset mid-frame done");

        // TX frames.
        tx_run(8'b10001111);
        tx_run(8'b00111001);

        // ctrl[1] re-raised during the frame and held past its end.
        f = {1'b1, 8'h5A, 1'b0};
        tx_data = 8'h5A;
        ctrl[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 3) ctrl[1] = 1'b0;
            if (i == 4) ctrl[1] = 1'b1;
            chk($sformatf("hold_bit%0d", i), tx_pin, (i < 10) ? f[i] : 1'b1);
        end
        chk("hold_no_restart", uart_state[0], 1'b0);
        chk("hold_done", uart_state[3], 1'b1);
        ctrl[1] = 1'b0;
        @(negedge clk);
        ctrl[1] = 1'b1;
        @(negedge clk);
        ctrl[1] = 1'b0;
        chk("restart_pin", tx_pin, 1'b0);
        chk("restart_busy", uart_state[0], 1'b1);
        chk("restart_done_clr", uart_state[3], 1'b0);
        repeat (11) @(negedge clk);
        chk("restart_finish", uart_state[3:0], 4'b1000);
        $display("tx held-start frame and restart done");

        // Full duplex at four clocks per bit.
        rxf4 = {1'b1, 8'h3C, 1'b0};
        txf4 = {1'b1, 8'hA5, 1'b0};
        tx_data4 = 8'hA5;
        @(negedge clk);
        prev4 = uart_state4;
        ctrl4[1] = 1'b1;
        rx_pin4 = rxf4[0];
        for (int c = 1; c < 70; c++) begin
            @(negedge clk);
            chk($sformatf("fd_stq%0d", c), status_q4, prev4);
            prev4 = uart_state4;
            if (c == 1) ctrl4[1] = 1'b0;
            rx_pin4 = (c < 40) ? rxf4[c / 4] : 1'b1;
            if (c <= 40) chk($sformatf("fd_tx%0d", c), tx_pin4, txf4[(c - 1) / 4]);
        end
        chk("fd_rx_data", rx_data4, 8'h3C);
        chk("fd_state", uart_state4, 8'h0C);
        chk("fd_tx_idle", tx_pin4, 1'b1);
        $display("full duplex tx A5 / rx got %02h", rx_data4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
